conv_fprop3_udiv_16ns_6ns_11_seq: RTL
=====================================

Name: conv_fprop3_udiv_16ns_6ns_11_seq

Overview:
- Sequential unsigned divider: restoring algorithm, one quotient bit per clock-enabled cycle.
- Inverse of the unsigned multiplier family used in the conv_fprop3 datapath. Recovers channel and row indices from flattened products, e.g. index/kernel_dim.
- Start/done handshake toward the HLS FSM; quotient and remainder are registered and held stable between operations.

Parameters:
- ID, 1, instance tag; no functional effect.
- din0_WIDTH, 16, dividend width; also the iteration count N.
- din1_WIDTH, 6, divisor width; also the remainder width.
- dout_WIDTH, 11, quotient output width; the quotient is truncated to this width (see Optional Feature).

Ports:
- ap_clk  in  1  clock; all state updates on the rising edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- ce  in  1  clock enable; when 0, every register holds, including done.
- start  in  1  operation request; sampled only in IDLE with ce=1.
- din0  in  din0_WIDTH  unsigned dividend; latched on accept.
- din1  in  din1_WIDTH  unsigned divisor; latched on accept.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle (ce-qualified) pulse; dout and remd are valid from this cycle on.
- dout  out  dout_WIDTH  quotient, held until the next done.
- remd  out  din1_WIDTH  remainder, held until the next done.

Behaviour:
- Reset (ap_rst_n=0, asynchronous): state=IDLE; busy=0, done=0, dout=0, remd=0; counter and working registers cleared. Deassertion is synchronous to ap_clk (external synchroniser).
- FSM, IDLE:
  - On an edge with ce=1 and start=1: latch din0 into the dividend shift register, latch din1 into the divisor register, clear the partial remainder (din1_WIDTH+1 bits), load counter=N, go to RUN.
  - start=0 or ce=0: stay in IDLE.
- FSM, RUN: on each ce=1 edge, one restoring iteration:
  - r' = {r[din1_WIDTH-1:0], dividend MSB}; shift the dividend left.
  - If r' >= divisor: r = r' - divisor, shift in quotient bit 1. Otherwise r = r', shift in 0.
  - Decrement the counter.
  - On the iteration where the counter reaches 0: go to IDLE, register dout = quotient[dout_WIDTH-1:0] and remd = r[din1_WIDTH-1:0], set done=1.
- done clears on the next ce=1 edge; it stays high while ce=0.
- Latency: the accepting edge is E0. Iterations run on edges E1..EN. done is high after EN. With N=16, that is 16 ce-active edges after acceptance.
- Throughput: one operation per N+1 ce-active edges.
- start in RUN is ignored; there is no queueing.
- start in the done cycle (state already IDLE) is accepted. done then drops and busy rises on the same edge (back-to-back operation).
- Divide by zero: no special case. Quotient = all ones; remd = dividend mod 2^din1_WIDTH (natural restoring result).
- The full internal quotient is din0_WIDTH bits; only the low dout_WIDTH bits are output.
- Reset asserted mid-RUN aborts the operation: no done pulse and all outputs return to 0.
- dout and remd change only on the done edge; they never glitch during RUN.

Optional Feature:
- Macro: CONV_FPROP3_UDIV_OVF_FLAG_EN.
- Defined:
  - Adds output port ovf (1 bit, reset 0), registered with done.
  - ovf=1 when the internal quotient has any nonzero bit at or above dout_WIDTH; dout then saturates to all ones.
  - ovf is held with dout until the next done.
- Undefined: no ovf port; dout is silently truncated to the low bits.

Test Plan:
- 1000/7, ce=1: done 16 edges after accept; dout=142, remd=6; busy high for exactly 16 cycles.
- 4096/1: macro off gives dout=0, remd=0. Macro on gives dout=2047, ovf=1.
- Divide by zero, 1234/0: dout=2047, remd=18; done asserted normally.
- ce held low for 5 cycles mid-RUN on 1000/7: done delayed by exactly 5 cycles; result unchanged (142/6). done stays high across a ce-low window.
- Back-to-back: start held high; first 500/10 then 63/63 accepted on the done cycle. Results dout=50/remd=0, then dout=1/remd=0; second done 17 edges after the first.
- Reset mid-RUN after 8 iterations: busy, done, dout and remd go to 0 immediately. No done pulse appears. A following 1000/7 returns 142/6.

Source files
------------

// File: rtl/conv_fprop3_udiv_16ns_6ns_11_seq.sv
// conv_fprop3_udiv_16ns_6ns_11_seq
// Sequential unsigned restoring divider, one quotient bit per ce-active edge.
// Recovers channel/row indices from flattened products in the conv_fprop3
// datapath (e.g. index / kernel_dim). Start/done handshake toward the HLS FSM.
// Optional feature: define CONV_FPROP3_UDIV_OVF_FLAG_EN to add an 'ovf' output
// and saturate dout when the quotient does not fit in dout_WIDTH bits.
module conv_fprop3_udiv_16ns_6ns_11_seq #(
  parameter int ID         = 1,
  parameter int din0_WIDTH = 16,
  parameter int din1_WIDTH = 6,
  parameter int dout_WIDTH = 11
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ce,
  input  logic                  start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  busy,
  output logic                  done,
  output logic [dout_WIDTH-1:0] dout,
  output logic [din1_WIDTH-1:0] remd
`ifdef CONV_FPROP3_UDIV_OVF_FLAG_EN
  ,
  output logic                  ovf
`endif
);

  localparam int CNT_W = $clog2(din0_WIDTH + 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  // Dividend shift register; quotient bits shift in at the LSB, so after
  // din0_WIDTH iterations it holds the full quotient.
  logic [din0_WIDTH-1:0] dvd_q, dvd_d;
  logic [din1_WIDTH-1:0] dsr_q, dsr_d;
  // Partial remainder. After every restore step it is below the divisor, so
  // its extra top bit is always zero and only din1_WIDTH bits are stored.
  logic [din1_WIDTH-1:0] rem_q, rem_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [dout_WIDTH-1:0] dout_q, dout_d;
  logic [din1_WIDTH-1:0] remd_q, remd_d;
`ifdef CONV_FPROP3_UDIV_OVF_FLAG_EN
  logic                  ovf_q, ovf_d;
  logic                  ovf_s;
`endif

  logic [din1_WIDTH:0]   rem_shift_s;
  logic                  q_bit_s;
  logic [din0_WIDTH-1:0] dvd_next_s;
  logic [din1_WIDTH-1:0] rem_next_s;

  // Next-state, datapath iteration and output register values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    rem_d   = rem_q;
    busy_d  = busy_q;
    done_d  = done_q;
    dout_d  = dout_q;
    remd_d  = remd_q;
`ifdef CONV_FPROP3_UDIV_OVF_FLAG_EN
    ovf_d   = ovf_q;
`endif

    rem_shift_s = {rem_q, dvd_q[din0_WIDTH-1]};
    q_bit_s     = (rem_shift_s >= {1'b0, dsr_q});
    dvd_next_s  = {dvd_q[din0_WIDTH-2:0], q_bit_s};
    rem_next_s  = din1_WIDTH'(q_bit_s ? (rem_shift_s - {1'b0, dsr_q}) : rem_shift_s);
`ifdef CONV_FPROP3_UDIV_OVF_FLAG_EN
    ovf_s       = |dvd_next_s[din0_WIDTH-1:dout_WIDTH];
`endif

    if (ce) begin
      // done is a single ce-qualified pulse
      done_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            dvd_d   = din0;
            dsr_d   = din1;
            rem_d   = {din1_WIDTH{1'b0}};
            cnt_d   = CNT_W'(din0_WIDTH);
            busy_d  = 1'b1;
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end
        RUN: begin
          dvd_d = dvd_next_s;
          rem_d = rem_next_s;
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            remd_d  = rem_next_s;
`ifdef CONV_FPROP3_UDIV_OVF_FLAG_EN
            ovf_d   = ovf_s;
            dout_d  = ovf_s ? {dout_WIDTH{1'b1}} : dvd_next_s[dout_WIDTH-1:0];
`else
            dout_d  = dvd_next_s[dout_WIDTH-1:0];
`endif
          end else begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end else begin
      // clock enable low: every register, including done, holds
      done_d = done_q;
    end
  end

  // State, datapath and output registers with asynchronous active-low reset.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      dvd_q   <= {din0_WIDTH{1'b0}};
      dsr_q   <= {din1_WIDTH{1'b0}};
      rem_q   <= {din1_WIDTH{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dout_q  <= {dout_WIDTH{1'b0}};
      remd_q  <= {din1_WIDTH{1'b0}};
`ifdef CONV_FPROP3_UDIV_OVF_FLAG_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dout_q  <= dout_d;
      remd_q  <= remd_d;
`ifdef CONV_FPROP3_UDIV_OVF_FLAG_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign dout = dout_q;
  assign remd = remd_q;
`ifdef CONV_FPROP3_UDIV_OVF_FLAG_EN
  assign ovf  = ovf_q;
`endif

endmodule
